aes_spi_master: RTL and testbench
=================================

Name: aes_spi_master

Overview:
- Parametrised SPI master that feeds an AES engine over a serial link.
- Serialises a variable-length key (NK words) and one 128-bit block to a selected slave (encrypt or decrypt unit). It then waits for the slave's done flag and shifts back the 128-bit result.
- Sits between the host/register side and the encryption/decryption units in the AES wrapper. It generalises the fixed single-slave master with AES-128/192/256 key support, N chip selects, a programmable SCLK divider and a done-timeout.

Parameters:
- NK, 4, key length in 32-bit words (legal: 4, 6, 8).
- NUM_SLAVES, 2, number of chip-select lines (0 = encrypt unit, 1 = decrypt unit).
- CLK_DIV, 4, clk cycles per SCLK half-period (≥1).
- TIMEOUT, 1023, max clk cycles to wait for slave_done.
- SEL_W, $clog2(NUM_SLAVES) (min 1), slave index width (derived).

Ports:
- clk  in  1  system clock
- rst  in  1  asynchronous active-low reset
- start  in  1  one-cycle request; accepted only in IDLE
- slave_sel  in  SEL_W  target slave, latched on accepted start
- key_in  in  32*NK  cipher key, latched on start
- msg_in  in  128  data block, latched on start
- busy  out  1  high from accepted start until return to IDLE
- result_out  out  128  received block, held until next result
- result_valid  out  1  one-cycle pulse when result_out updates
- timeout_err  out  1  one-cycle pulse on slave_done timeout
- sclk  out  1  SPI clock, idle low (mode 0)
- mosi  out  1  serial data out, MSB first
- miso  in  1  serial data in, MSB first
- cs_n  out  NUM_SLAVES  active-low chip selects, one-hot-low when active
- slave_done  in  1  slave finished processing (same clk domain)

Behaviour:
- Reset (rst=0, async): state IDLE; sclk=0, mosi=0, cs_n=all 1, busy=0, result_out=0, result_valid=0, timeout_err=0; all counters and shift registers 0.
- Transaction state machine:
  - IDLE: on start=1, latch slave_sel, key_in, msg_in. Load the TX shift register as {key_in, msg_in}: LEN=32*NK+128 bits, key MSB first. Drop cs_n[slave_sel], set busy → SETUP.
  - SETUP: hold for CLK_DIV cycles (CS-to-first-edge setup), with mosi = TX MSB → SHIFT_TX.
  - SHIFT_TX: the divider counts CLK_DIV cycles per half-period. On each rising sclk, count the bit. On each falling sclk, shift TX left and drive the next bit on mosi. After LEN rising edges and the following falling edge → WAIT_DONE, with sclk low and mosi=0.
  - WAIT_DONE: cs_n stays low and sclk stays idle; the timeout counter increments each cycle.
    - slave_done=1 → SHIFT_RX.
    - Counter reaches TIMEOUT with no done → pulse timeout_err, release cs_n → IDLE. result_out is unchanged.
  - SHIFT_RX: 128 SCLK periods. miso is sampled into the RX shift register (shift left, LSB in) on each rising sclk. After the 128th falling edge → FINISH.
  - FINISH: result_out ← RX, result_valid=1 for exactly this cycle, cs_n all 1 → IDLE (busy drops the next cycle).
- Timing: one bit = 2*CLK_DIV clk cycles.
  - NK=4, CLK_DIV=4: TX = 256 bits = 2048 cycles.
  - Start-to-result_valid latency = 1 + CLK_DIV + 2*CLK_DIV*LEN + D + 2*CLK_DIV*128 + 1, where D is the cycles in WAIT_DONE.
- start while busy: ignored; latched inputs do not change.
- slave_done outside WAIT_DONE: ignored.
- slave_sel ≥ NUM_SLAVES: the start is rejected, FSM stays IDLE, no cs_n asserted.
- slave_done and timeout expiry in the same cycle: done wins.
- rst asserted mid-transfer: immediate return to reset values; cs_n deasserts asynchronously.
- Bit counter width: $clog2(32*8+128+1), sized for the largest legal NK.

Decomposition:
- Shared package aes_pkg:
  - state enum (IDLE, SETUP, SHIFT_TX, WAIT_DONE, SHIFT_RX, FINISH)
  - BLOCK_W=128
  - WORD_W=32
  - legal NK constants
- One sub-module, spi_clk_gen:
  - divider counter producing sclk, rise_tick and fall_tick
  - enable input; forces sclk low when disabled

Test Plan:
- FIPS-197 AES-128:
  - Stimulus: NK=4, slave_sel=0, key 000102030405060708090a0b0c0d0e0f, msg 00112233445566778899aabbccddeeff. The slave model captures 256 bits and returns 69c4e0d86a7b0430d8cdb78070b4c55a after 20 cycles.
  - Required: captured bits match {key,msg}; result_out equals the returned value; one result_valid pulse; latency matches the formula.
- AES-256 build (NK=8), slave_sel=1:
  - Stimulus: any key and message.
  - Required: exactly 384 TX sclk rising edges; only cs_n[1] low; cs_n[0] stays 1 throughout.
- Timeout:
  - Stimulus: slave_done never asserted, TIMEOUT=1023.
  - Required: timeout_err pulses exactly 1023 cycles after WAIT_DONE entry; cs_n returns all 1; result_out keeps its previous value; result_valid never pulses.
- Start while busy:
  - Stimulus: start pulsed mid-SHIFT_TX with a different msg_in.
  - Required: transmitted bits equal the original message; one transaction only.
- Async reset:
  - Stimulus: rst=0 asserted midway through SHIFT_RX, between clk edges.
  - Required: cs_n=all 1, sclk=0, busy=0 immediately; a new start after release completes normally.
- Divider corner:
  - Stimulus: CLK_DIV=1.
  - Required: sclk toggles every clk; mosi is stable at every rising sclk; the end-to-end loopback result is correct.

Source files
------------

// File: rtl/aes_pkg.sv
// rtl/aes_pkg.sv - shared types and constants for the AES SPI master
package aes_pkg;

    typedef enum logic [2:0] {
        IDLE,
        SETUP,
        SHIFT_TX,
        WAIT_DONE,
        SHIFT_RX,
        FINISH
    } state_t;

    localparam int BLOCK_W = 128;
    localparam int WORD_W  = 32;

    localparam int NK_128 = 4;
    localparam int NK_192 = 6;
    localparam int NK_256 = 8;

    // Bit counter is sized for the longest key so every build shares one width.
    localparam int BIT_CNT_W = $clog2(WORD_W * NK_256 + BLOCK_W + 1);

    function automatic logic nk_is_legal(input int nk);
        return (nk == NK_128) || (nk == NK_192) || (nk == NK_256);
    endfunction

endpackage

// File: rtl/spi_clk_gen.sv
// rtl/spi_clk_gen.sv - SCLK divider with rise/fall ticks, idle low when disabled
module spi_clk_gen #(
    parameter int CLK_DIV = 4
) (
    input  logic clk,
    input  logic rst_n,
    input  logic en,
    output logic sclk,
    output logic rise_tick,
    output logic fall_tick
);

    localparam int CNT_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(CLK_DIV - 1);

    logic [CNT_W-1:0] cnt;
    logic             half_done;

    // Ticks flag the clk edge at which sclk is about to change.
    assign half_done = en && (cnt == CNT_MAX);
    assign rise_tick = half_done && !sclk;
    assign fall_tick = half_done && sclk;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt  <= '0;
            sclk <= 1'b0;
        end else if (!en) begin
            cnt  <= '0;
            sclk <= 1'b0;
        end else if (half_done) begin
            cnt  <= '0;
            sclk <= ~sclk;
        end else begin
            cnt <= cnt + 1'b1;
        end
    end

endmodule

// File: rtl/aes_spi_master.sv
// rtl/aes_spi_master.sv - SPI master sending key+block to an AES slave and reading the result
module aes_spi_master
    import aes_pkg::*;
#(
    parameter int NK         = 4,
    parameter int NUM_SLAVES = 2,
    parameter int CLK_DIV    = 4,
    parameter int TIMEOUT    = 1023,
    parameter int SEL_W      = (NUM_SLAVES > 1) ? $clog2(NUM_SLAVES) : 1
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start,
    input  logic [SEL_W-1:0]      slave_sel,
    input  logic [WORD_W*NK-1:0]  key_in,
    input  logic [BLOCK_W-1:0]    msg_in,
    output logic                  busy,
    output logic [BLOCK_W-1:0]    result_out,
    output logic                  result_valid,
    output logic                  timeout_err,
    output logic                  sclk,
    output logic                  mosi,
    input  logic                  miso,
    output logic [NUM_SLAVES-1:0] cs_n,
    input  logic                  slave_done
);

    localparam int LEN      = WORD_W * NK + BLOCK_W;
    localparam int WAIT_MAX = (TIMEOUT > CLK_DIV) ? TIMEOUT : CLK_DIV;
    localparam int TMO_W    = $clog2(WAIT_MAX + 1);

    localparam logic [BIT_CNT_W-1:0]  TX_BITS    = BIT_CNT_W'(LEN);
    localparam logic [BIT_CNT_W-1:0]  RX_BITS    = BIT_CNT_W'(BLOCK_W);
    localparam logic [TMO_W-1:0]      SETUP_LAST = TMO_W'(CLK_DIV - 1);
    localparam logic [TMO_W-1:0]      TMO_LAST   = TMO_W'(TIMEOUT - 1);
    localparam logic [NUM_SLAVES-1:0] CS_ONE     = NUM_SLAVES'(1);

    state_t               state, state_nxt;
    logic [LEN-1:0]       tx_sr;
    logic [BLOCK_W-1:0]   rx_sr;
    logic [BIT_CNT_W-1:0] bit_cnt;
    logic [TMO_W-1:0]     wait_cnt;
    logic                 clk_en;
    logic                 rise_tick;
    logic                 fall_tick;
    logic                 sel_ok;

    assign sel_ok = (int'(slave_sel) < NUM_SLAVES);

    spi_clk_gen #(
        .CLK_DIV(CLK_DIV)
    ) u_clk_gen (
        .clk      (clk),
        .rst_n    (rst),
        .en       (clk_en),
        .sclk     (sclk),
        .rise_tick(rise_tick),
        .fall_tick(fall_tick)
    );

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt    = state;
        busy         = (state != IDLE);
        result_valid = (state == FINISH);
        clk_en       = (state == SHIFT_TX) || (state == SHIFT_RX);
        case (state)
            IDLE:      if (start && sel_ok) state_nxt = SETUP;
            SETUP:     if (wait_cnt == SETUP_LAST) state_nxt = SHIFT_TX;
            SHIFT_TX:  if (fall_tick && bit_cnt == TX_BITS) state_nxt = WAIT_DONE;
            // A done arriving on the last allowed cycle still wins over the timeout.
            WAIT_DONE: begin
                if (slave_done) begin
                    state_nxt = SHIFT_RX;
                end else if (wait_cnt == TMO_LAST) begin
                    state_nxt = IDLE;
                end
            end
            SHIFT_RX:  if (fall_tick && bit_cnt == RX_BITS) state_nxt = FINISH;
            FINISH:    state_nxt = IDLE;
            default:   state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            tx_sr       <= '0;
            rx_sr       <= '0;
            bit_cnt     <= '0;
            wait_cnt    <= '0;
            mosi        <= 1'b0;
            cs_n        <= '1;
            result_out  <= '0;
            timeout_err <= 1'b0;
        end else begin
            timeout_err <= 1'b0;
            case (state)
                IDLE: begin
                    if (start && sel_ok) begin
                        tx_sr    <= {key_in, msg_in};
                        mosi     <= key_in[WORD_W*NK-1];
                        cs_n     <= ~(CS_ONE << slave_sel);
                        bit_cnt  <= '0;
                        wait_cnt <= '0;
                    end
                end
                SETUP: wait_cnt <= wait_cnt + 1'b1;
                SHIFT_TX: begin
                    if (rise_tick) begin
                        bit_cnt <= bit_cnt + 1'b1;
                    end
                    // mosi only moves on falling sclk so it is stable at every rising edge.
                    if (fall_tick) begin
                        if (bit_cnt == TX_BITS) begin
                            mosi     <= 1'b0;
                            bit_cnt  <= '0;
                            wait_cnt <= '0;
                        end else begin
                            tx_sr <= tx_sr << 1;
                            mosi  <= tx_sr[LEN-2];
                        end
                    end
                end
                WAIT_DONE: begin
                    wait_cnt <= wait_cnt + 1'b1;
                    if (!slave_done && wait_cnt == TMO_LAST) begin
                        timeout_err <= 1'b1;
                        cs_n        <= '1;
                    end
                end
                SHIFT_RX: begin
                    if (rise_tick) begin
                        rx_sr   <= {rx_sr[BLOCK_W-2:0], miso};
                        bit_cnt <= bit_cnt + 1'b1;
                    end
                    if (fall_tick && bit_cnt == RX_BITS) begin
                        result_out <= rx_sr;
                    end
                end
                FINISH: cs_n <= '1;
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_aes_spi_master.sv
// tb/tb_aes_spi_master.sv - directed self-checking bench for aes_spi_master
module tb_aes_spi_master;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    logic         rst;
    logic         start_a, start_b, start_c;
    logic [1:0]   sel;
    logic [255:0] key;
    logic [127:0] msg;
    logic         done_m, miso_m;
    int           act = 0;

    logic busy_a, rv_a, tmo_a, sclk_a, mosi_a; logic [127:0] res_a; logic [1:0] cs_a;
    logic busy_b, rv_b, tmo_b, sclk_b, mosi_b; logic [127:0] res_b; logic [1:0] cs_b;
    logic busy_c, rv_c, tmo_c, sclk_c, mosi_c; logic [127:0] res_c; logic [2:0] cs_c;

    aes_spi_master #(.NK(4), .NUM_SLAVES(2), .CLK_DIV(4), .TIMEOUT(1023)) dut_a (
        .clk(clk), .rst(rst), .start(start_a), .slave_sel(sel[0:0]), .key_in(key[127:0]),
        .msg_in(msg), .busy(busy_a), .result_out(res_a), .result_valid(rv_a),
        .timeout_err(tmo_a), .sclk(sclk_a), .mosi(mosi_a), .miso(miso_m), .cs_n(cs_a),
        .slave_done(done_m && act == 0));

    aes_spi_master #(.NK(8), .NUM_SLAVES(2), .CLK_DIV(2), .TIMEOUT(1023)) dut_b (
        .clk(clk), .rst(rst), .start(start_b), .slave_sel(sel[0:0]), .key_in(key),
        .msg_in(msg), .busy(busy_b), .result_out(res_b), .result_valid(rv_b),
        .timeout_err(tmo_b), .sclk(sclk_b), .mosi(mosi_b), .miso(miso_m), .cs_n(cs_b),
        .slave_done(done_m && act == 1));

    aes_spi_master #(.NK(4), .NUM_SLAVES(3), .CLK_DIV(1), .TIMEOUT(1023)) dut_c (
        .clk(clk), .rst(rst), .start(start_c), .slave_sel(sel), .key_in(key[127:0]),
        .msg_in(msg), .busy(busy_c), .result_out(res_c), .result_valid(rv_c),
        .timeout_err(tmo_c), .sclk(sclk_c), .mosi(mosi_c), .miso(miso_m), .cs_n(cs_c),
        .slave_done(done_m && act == 2));

    logic m_sclk, m_mosi, m_rv, m_tmo, m_busy;
    logic [2:0]   m_cs;
    logic [127:0] m_res;
    always_comb begin
        m_sclk = sclk_c; m_mosi = mosi_c; m_rv = rv_c; m_tmo = tmo_c;
        m_busy = busy_c; m_cs = cs_c; m_res = res_c;
        if (act == 0) begin
            m_sclk = sclk_a; m_mosi = mosi_a; m_rv = rv_a; m_tmo = tmo_a;
            m_busy = busy_a; m_cs = {1'b1, cs_a}; m_res = res_a;
        end else if (act == 1) begin
            m_sclk = sclk_b; m_mosi = mosi_b; m_rv = rv_b; m_tmo = tmo_b;
            m_busy = busy_b; m_cs = {1'b1, cs_b}; m_res = res_b;
        end
    end

    // Slave model state
    int           phase, rises, wcnt, rcnt, resp_delay, exp_len, unstable, hold;
    int           rv_count, tmo_count, valid_cyc, tmo_cyc, entry_cyc, c0;
    logic [383:0] cap;
    logic [127:0] resp;
    logic [2:0]   cs_low_seen, tmo_cs;
    logic         prev_sclk, mosi_prev, loopback;
    int           errors = 0;
    int           checks = 0;

    initial begin
        phase = 0; rises = 0; wcnt = 0; rcnt = 0; resp_delay = 0; exp_len = 256;
        unstable = 0; hold = 0; rv_count = 0; tmo_count = 0; valid_cyc = 0; tmo_cyc = 0;
        entry_cyc = 0; cap = '0; resp = '0; cs_low_seen = '0; tmo_cs = '0;
        prev_sclk = 1'b0; mosi_prev = 1'b0; loopback = 1'b0; done_m = 1'b0; miso_m = 1'b0;
        forever begin
            @(negedge clk);
            if (m_rv) begin rv_count++; valid_cyc = cyc; end
            if (m_tmo) begin tmo_count++; tmo_cyc = cyc; tmo_cs = m_cs; end
            for (int i = 0; i < 3; i++) if (!m_cs[i]) cs_low_seen[i] = 1'b1;
            if (&m_cs) begin
                phase = 0;
                done_m = 1'b0;
            end else if (phase == 0) begin
                if (rises > 0 && m_sclk === prev_sclk) hold++;
                if (m_sclk && !prev_sclk) begin
                    cap = {cap[382:0], m_mosi};
                    rises++;
                    if (m_mosi !== mosi_prev) unstable++;
                end else if (!m_sclk && prev_sclk && rises == exp_len) begin
                    phase = 1; entry_cyc = cyc; wcnt = 1;
                    if (loopback) resp = cap[127:0];
                    if (wcnt == resp_delay) begin done_m = 1'b1; miso_m = resp[127]; end
                end
            end else if (phase == 1) begin
                if (done_m) begin
                    phase = 2; done_m = 1'b0; rcnt = 0;
                end else begin
                    wcnt++;
                    if (wcnt == resp_delay) begin done_m = 1'b1; miso_m = resp[127]; end
                end
            end else begin
                if (!m_sclk && prev_sclk) begin
                    rcnt++;
                    if (rcnt < 128) miso_m = resp[127-rcnt];
                end
            end
            prev_sclk = m_sclk;
            mosi_prev = m_mosi;
        end
    end

    task automatic clear_obs();
        rises = 0; cap = '0; unstable = 0; hold = 0; rv_count = 0; tmo_count = 0;
        valid_cyc = 0; tmo_cyc = 0; entry_cyc = 0; cs_low_seen = '0; tmo_cs = '0;
        loopback = 1'b0;
    endtask

    task automatic kick(input int which);
        @(negedge clk);
        c0 = cyc;
        if (which == 0) start_a = 1'b1;
        else if (which == 1) start_b = 1'b1;
        else start_c = 1'b1;
        @(negedge clk);
        start_a = 1'b0; start_b = 1'b0; start_c = 1'b0;
    endtask

    task automatic run_wait(input int budget, output bit ok);
        ok = 1'b0;
        for (int i = 0; i < budget; i++) begin
            @(negedge clk);
            if (!m_busy) begin ok = 1'b1; break; end
        end
        repeat (2) @(negedge clk);
    endtask

    task automatic test_reset();
        rst = 1'b0; start_a = 0; start_b = 0; start_c = 0; sel = 0; key = '0; msg = '0; act = 0;
        repeat (3) @(negedge clk);
        checks++; if (res_a !== 128'h0) begin errors++; $display("FAIL reset_result got=%h exp=0", res_a); end
        checks++; if (busy_a !== 1'b0) begin errors++; $display("FAIL reset_busy got=%b exp=0", busy_a); end
        checks++; if (cs_a !== 2'b11) begin errors++; $display("FAIL reset_cs got=%b exp=11", cs_a); end
        checks++; if (sclk_a !== 1'b0 || mosi_a !== 1'b0) begin errors++; $display("FAIL reset_sclk_mosi got=%b%b exp=00", sclk_a, mosi_a); end
        checks++; if (rv_a !== 1'b0 || tmo_a !== 1'b0) begin errors++; $display("FAIL reset_pulses got=%b%b exp=00", rv_a, tmo_a); end
        checks++; if (cs_c !== 3'b111) begin errors++; $display("FAIL reset_cs_c got=%b exp=111", cs_c); end
        @(negedge clk);
        rst = 1'b1;
        repeat (2) @(negedge clk);
    endtask

    task automatic test_fips128();
        bit ok;
        act = 0; clear_obs(); exp_len = 256; resp_delay = 20;
        resp = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
        key = {128'h0, 128'h000102030405060708090a0b0c0d0e0f};
        msg = 128'h00112233445566778899aabbccddeeff; sel = 2'd0;
        kick(0);
        run_wait(4000, ok);
        checks++; if (!ok) begin errors++; $display("FAIL fips_done got=timeout exp=idle"); end
        checks++; if (cap[255:0] !== {128'h000102030405060708090a0b0c0d0e0f, 128'h00112233445566778899aabbccddeeff})
            begin errors++; $display("FAIL fips_tx got=%h", cap[255:0]); end
        checks++; if (res_a !== 128'h69c4e0d86a7b0430d8cdb78070b4c55a) begin errors++; $display("FAIL fips_result got=%h", res_a); end
        checks++; if (rv_count != 1) begin errors++; $display("FAIL fips_valid_pulses got=%0d exp=1", rv_count); end
        checks++; if (valid_cyc - c0 + 1 != 3098) begin errors++; $display("FAIL fips_latency got=%0d exp=3098", valid_cyc - c0 + 1); end
        checks++; if (cs_low_seen !== 3'b001) begin errors++; $display("FAIL fips_cs got=%b exp=001", cs_low_seen); end
    endtask

    task automatic test_timeout();
        bit ok;
        act = 0; clear_obs(); exp_len = 256; resp_delay = 0;
        msg = 128'hdeadbeef_00000000_cafef00d_12345678; sel = 2'd0;
        kick(0);
        run_wait(4000, ok);
        checks++; if (!ok) begin errors++; $display("FAIL tmo_done got=timeout exp=idle"); end
        checks++; if (tmo_count != 1) begin errors++; $display("FAIL tmo_pulses got=%0d exp=1", tmo_count); end
        checks++; if (tmo_cyc - entry_cyc != 1023) begin errors++; $display("FAIL tmo_delay got=%0d exp=1023", tmo_cyc - entry_cyc); end
        checks++; if (tmo_cs !== 3'b111 || cs_a !== 2'b11) begin errors++; $display("FAIL tmo_cs got=%b exp=111", tmo_cs); end
        checks++; if (rv_count != 0) begin errors++; $display("FAIL tmo_valid got=%0d exp=0", rv_count); end
        checks++; if (res_a !== 128'h69c4e0d86a7b0430d8cdb78070b4c55a) begin errors++; $display("FAIL tmo_result_kept got=%h", res_a); end
    endtask

    task automatic test_start_while_busy();
        bit ok;
        act = 0; clear_obs(); exp_len = 256; resp_delay = 5;
        resp = 128'h0123456789abcdef_fedcba9876543210;
        key = {128'h0, 128'ha5a5a5a5_5a5a5a5a_0f0f0f0f_f0f0f0f0};
        msg = 128'h11111111_22222222_33333333_44444444; sel = 2'd0;
        kick(0);
        repeat (600) @(negedge clk);
        msg = 128'h99999999_88888888_77777777_66666666;
        start_a = 1'b1;
        @(negedge clk);
        start_a = 1'b0;
        run_wait(4000, ok);
        checks++; if (!ok) begin errors++; $display("FAIL busy_done got=timeout exp=idle"); end
        checks++; if (cap[255:0] !== {128'ha5a5a5a5_5a5a5a5a_0f0f0f0f_f0f0f0f0, 128'h11111111_22222222_33333333_44444444})
            begin errors++; $display("FAIL busy_tx got=%h", cap[255:0]); end
        checks++; if (res_a !== 128'h0123456789abcdef_fedcba9876543210) begin errors++; $display("FAIL busy_result got=%h", res_a); end
        repeat (50) @(negedge clk);
        checks++; if (rv_count != 1 || rises != 256 || busy_a !== 1'b0)
            begin errors++; $display("FAIL busy_single got=%0d/%0d/%b exp=1/256/0", rv_count, rises, busy_a); end
    endtask

    task automatic test_async_reset();
        bit ok;
        bit found;
        act = 0; clear_obs(); exp_len = 256; resp_delay = 3;
        resp = 128'hf0e1d2c3_b4a59687_78695a4b_3c2d1e0f;
        kick(0);
        found = 1'b0;
        for (int i = 0; i < 4000; i++) begin
            @(negedge clk);
            if (phase == 2 && rcnt >= 64) begin found = 1'b1; break; end
        end
        checks++; if (!found) begin errors++; $display("FAIL arst_reach_rx got=timeout exp=rx"); end
        #2 rst = 1'b0;
        #1;
        checks++; if (cs_a !== 2'b11 || sclk_a !== 1'b0 || busy_a !== 1'b0)
            begin errors++; $display("FAIL arst_immediate got=%b/%b/%b exp=11/0/0", cs_a, sclk_a, busy_a); end
        checks++; if (res_a !== 128'h0) begin errors++; $display("FAIL arst_result got=%h exp=0", res_a); end
        @(negedge clk);
        rst = 1'b1;
        repeat (2) @(negedge clk);
        clear_obs(); resp = 128'h00000000_11111111_aaaaaaaa_ffffffff; resp_delay = 2;
        kick(0);
        run_wait(4000, ok);
        checks++; if (!ok || res_a !== 128'h00000000_11111111_aaaaaaaa_ffffffff || rv_count != 1)
            begin errors++; $display("FAIL arst_restart got=%h/%0d", res_a, rv_count); end
    endtask

    task automatic test_aes256();
        bit ok;
        act = 1; clear_obs(); exp_len = 384; resp_delay = 7;
        resp = 128'h8ea2b7ca516745bfeafc49904b496089;
        key = 256'h000102030405060708090a0b0c0d0e0f101112131415161718191a1b1c1d1e1f;
        msg = 128'h00112233445566778899aabbccddeeff; sel = 2'd1;
        kick(1);
        run_wait(4000, ok);
        checks++; if (!ok) begin errors++; $display("FAIL k256_done got=timeout exp=idle"); end
        checks++; if (rises != 384) begin errors++; $display("FAIL k256_edges got=%0d exp=384", rises); end
        checks++; if (cap !== {256'h000102030405060708090a0b0c0d0e0f101112131415161718191a1b1c1d1e1f,
                               128'h00112233445566778899aabbccddeeff})
            begin errors++; $display("FAIL k256_tx got=%h", cap); end
        checks++; if (cs_low_seen !== 3'b010) begin errors++; $display("FAIL k256_cs got=%b exp=010", cs_low_seen); end
        checks++; if (res_b !== 128'h8ea2b7ca516745bfeafc49904b496089) begin errors++; $display("FAIL k256_result got=%h", res_b); end
        checks++; if (valid_cyc - c0 + 1 != 2059) begin errors++; $display("FAIL k256_latency got=%0d exp=2059", valid_cyc - c0 + 1); end
    endtask

    task automatic test_div1();
        bit ok;
        act = 2; clear_obs(); exp_len = 256; resp_delay = 4;
        key = {128'h0, 128'h2b7e1516_28aed2a6_abf71588_09cf4f3c};
        msg = 128'h3243f6a8_885a308d_313198a2_e0370734; sel = 2'd3;
        kick(2);
        repeat (5) @(negedge clk);
        checks++; if (busy_c !== 1'b0 || cs_c !== 3'b111 || cs_low_seen !== 3'b000)
            begin errors++; $display("FAIL div1_reject got=%b/%b exp=0/111", busy_c, cs_c); end
        clear_obs(); loopback = 1'b1; sel = 2'd2;
        kick(2);
        run_wait(2000, ok);
        checks++; if (!ok) begin errors++; $display("FAIL div1_done got=timeout exp=idle"); end
        checks++; if (res_c !== 128'h3243f6a8_885a308d_313198a2_e0370734) begin errors++; $display("FAIL div1_loopback got=%h", res_c); end
        checks++; if (unstable != 0) begin errors++; $display("FAIL div1_mosi_stable got=%0d exp=0", unstable); end
        checks++; if (hold != 0 || rises != 256) begin errors++; $display("FAIL div1_toggle got=%0d/%0d exp=0/256", hold, rises); end
        checks++; if (cs_low_seen !== 3'b100 || rv_count != 1) begin errors++; $display("FAIL div1_cs got=%b/%0d exp=100/1", cs_low_seen, rv_count); end
        checks++; if (valid_cyc - c0 + 1 != 775) begin errors++; $display("FAIL div1_latency got=%0d exp=775", valid_cyc - c0 + 1); end
    endtask

    initial begin
        test_reset();
        test_fips128();
        test_timeout();
        test_start_while_busy();
        test_async_reset();
        test_aes256();
        test_div1();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
